// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts enabled cycles and flags the cycle the count hits TIMEOUT_CYCLES-1
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  always_ff @(posedge clk_i)
    if (rst_i || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 16'd1;
  assign expire_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding imem fetch with decode handshake, flush and watchdog.
// Define FETCH_MISALIGN_TRAP_EN to fault on misaligned PCs instead of masking the low bits.
module instr_fetch_unit import fetch_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_instr_o,
  output logic [XLEN-1:0] dec_pc_o,
  output logic            dec_fault_o,
  output logic            pc_adv_o
);
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d;
  logic fault_q, fault_d, drop_q, drop_d;
  logic misalign, gnt_ok, expire;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = pc_i[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif
  // While a dropped response is still owed, no new request may go out
  assign imem_req_o  = !RST && state_q == REQ && !drop_q && !misalign;
  assign imem_addr_o = {pc_i[XLEN-1:2], 2'b00};
  assign gnt_ok      = imem_req_o && imem_gnt_i;
  assign dec_valid_o = state_q == HOLD;
  assign pc_adv_o    = !RST && dec_valid_o && dec_ready_i && !flush_i;
  assign dec_instr_o = instr_q;
  assign dec_pc_o    = pc_q;
  assign dec_fault_o = fault_q;
  fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk_i(CLK),
    .rst_i(RST),
    .clr_i(gnt_ok && !flush_i),
    .en_i(state_q == WAIT),
    .expire_o(expire)
  );
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    drop_d  = drop_q && !imem_rvalid_i;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:
        if (flush_i) begin
          drop_d = drop_d || gnt_ok;
        end else if (misalign) begin
          state_d = HOLD;
          pc_d    = pc_i;
          instr_d = NOP_INSTR;
          fault_d = 1'b1;
        end else if (gnt_ok) begin
          state_d = WAIT;
          pc_d    = pc_i;
        end
      WAIT:
        if (flush_i) begin
          state_d = REQ;
          drop_d  = !imem_rvalid_i;
        end else if (imem_rvalid_i) begin
          state_d = HOLD;
          instr_d = imem_rdata_i;
          fault_d = 1'b0;
        end else if (expire) begin
          state_d = HOLD;
          instr_d = NOP_INSTR;
          fault_d = 1'b1;
          drop_d  = 1'b1;
        end
      HOLD: state_d = (flush_i || dec_ready_i) ? REQ : HOLD;
    endcase
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      fault_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      drop_q  <= drop_d;
    end
endmodule
